addsubcmp_arbiter: RTL and testbench

Shares one 16-bit AddSubCmp add/subtract/compare unit among `NumReq` requesters. A round-robin scheduler grants one request at a time, latches its operands and opcode, and sequences the shared unit. It returns a registered result, flags and a condition bit with a one-cycle acknowledge. It sits between several sensor/peripheral FSMs and the single arithmetic resource, replacing per-FSM comparators.

---
 rtl/addsubcmp_arbiter.sv | 138 +++++++++++++
 tb/tb_addsubcmp_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsubcmp_arbiter.sv
// Round-robin arbiter sharing one 16-bit add/sub/compare unit among NumReq requesters.
// Latency: request sampled in IDLE -> Ack_o two cycles later; one operation every 3 cycles.
// Backpressure: requesters hold Req_i until Ack_o; requests seen while busy wait for the next IDLE.
module addsubcmp_arbiter #(
  parameter int NumReq = 4
) (
  input  logic                   Clk_i,
  input  logic                   Reset_n_i,
  input  logic [NumReq-1:0]      Req_i,
  input  logic [2*NumReq-1:0]    Op_i,
  input  logic [16*NumReq-1:0]   A_i,
  input  logic [16*NumReq-1:0]   B_i,
  output logic [NumReq-1:0]      Ack_o,
  output logic [15:0]            Result_o,
  output logic [3:0]             Flags_o,
  output logic                   Cond_o,
  output logic                   Busy_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LESS = 2'b10;
  localparam logic [1:0] OP_EQ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   grant_q;
  logic [1:0]        op_q;
  logic [15:0]       a_q, b_q;

  logic              found;
  logic [PtrW-1:0]   sel;
  int                idx;

  logic [15:0]       unit_a, unit_b, b_eff;
  logic              unit_sub;
  logic [16:0]       sum;
  logic [15:0]       res;
  logic              carry, zero, sign, ovf, cond;

  // Round-robin pick: first set request at or above ptr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(ptr_q) + i) % NumReq;
      if (!found && Req_i[idx]) begin
        found = 1'b1;
        sel   = PtrW'(idx);
      end
    end
  end

  // Shared add/sub unit on the latched operands; LESS swaps inputs to form B-A.
  always_comb begin
    unit_a   = (op_q == OP_LESS) ? b_q : a_q;
    unit_b   = (op_q == OP_LESS) ? a_q : b_q;
    unit_sub = (op_q != OP_ADD);
    b_eff    = unit_sub ? ~unit_b : unit_b;
    sum      = {1'b0, unit_a} + {1'b0, b_eff} + {16'b0, unit_sub};
    res      = sum[15:0];
    carry    = sum[16];
    zero     = (res == 16'h0000);
    sign     = res[15];
    ovf      = (unit_a[15] == b_eff[15]) && (res[15] != unit_a[15]);
    case (op_q)
      OP_ADD:  cond = carry;
      OP_SUB:  cond = carry;
      OP_LESS: cond = carry & ~zero;
      OP_EQ:   cond = zero;
      default: cond = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state and decoded outputs: Ack_o only in RESP, Busy_o outside IDLE.
  always_comb begin
    state_d = state_q;
    Ack_o   = '0;
    Busy_o  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        Busy_o = 1'b0;
        if (found) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        Ack_o[grant_q] = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant latch in IDLE, result capture at the end of EXEC, pointer advance in RESP.
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      ptr_q    <= '0;
      grant_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      Result_o <= '0;
      Flags_o  <= '0;
      Cond_o   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && found) begin
        grant_q <= sel;
        op_q    <= Op_i[2*int'(sel) +: 2];
        a_q     <= A_i[16*int'(sel) +: 16];
        b_q     <= B_i[16*int'(sel) +: 16];
      end
      if (state_q == ST_EXEC) begin
        Result_o <= res;
        Flags_o  <= {ovf, sign, zero, carry};
        Cond_o   <= cond;
      end
      if (state_q == ST_RESP) begin
        ptr_q <= (grant_q == PtrW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addsubcmp_arbiter.sv
// Randomized and directed bench for addsubcmp_arbiter with a queue-based scoreboard.
// Expected responses are pushed in predicted round-robin order; a monitor pops on every Ack.
// Requesters drop Req as soon as they see their Ack.
module tb_addsubcmp_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [2*N-1:0]    op_in;
  logic [16*N-1:0]   a_in, b_in;
  logic [N-1:0]      ack;
  logic [15:0]       result;
  logic [3:0]        flags;
  logic              cond;
  logic              busy;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] res;
    logic [3:0]  flags;
    logic        cond;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mptr     = 0;

  always #5 clk = ~clk;

  addsubcmp_arbiter #(.NumReq(N)) dut (
    .Clk_i(clk), .Reset_n_i(rst_n), .Req_i(req), .Op_i(op_in),
    .A_i(a_in), .B_i(b_in), .Ack_o(ack), .Result_o(result),
    .Flags_o(flags), .Cond_o(cond), .Busy_o(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int k, input logic [1:0] o,
                                 input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   sx, sy, full, sres;
    logic c, v;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0: begin full = int'(x) + int'(y); sres = sx + sy; c = (full > 65535); end
      2'd2: begin full = int'(y) - int'(x); sres = sy - sx; c = (y >= x); end
      default: begin full = int'(x) - int'(y); sres = sx - sy; c = (x >= y); end
    endcase
    v       = (sres > 32767) || (sres < -32768);
    e.idx   = k[1:0];
    e.res   = full[15:0];
    e.flags = {v, e.res[15], (e.res == 16'h0000), c};
    case (o)
      2'd2:    e.cond = (x < y);
      2'd3:    e.cond = (x == y);
      default: e.cond = c;
    endcase
    return e;
  endfunction

  task automatic set_req(input int k, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    op_in[2*k +: 2] = o;
    a_in[16*k +: 16] = x;
    b_in[16*k +: 16] = y;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue all requesters in mask at once from IDLE; acks must arrive 2,5,8,.. cycles later.
  task automatic run_round(input logic [N-1:0] mask, input bit disturb);
    int j = 0;
    int cyc = 0;
    int last = 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (mptr + i) % N;
      if (mask[k]) begin
        exp_q.push_back(model(k, op_in[2*k +: 2], a_in[16*k +: 16], b_in[16*k +: 16]));
        last = k;
      end
    end
    mptr = (last + 1) % N;
    req = mask;
    while (req != '0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 1) begin
        a_in = ~a_in;
        b_in = ~b_in;
      end
      if (ack != '0) begin
        check("ack_cycle", cyc, 2 + 3*j);
        j++;
        req = req & ~ack;
      end
    end
    if (req != '0) check("round_timeout", 32'(req), 0);
    req = '0;
    @(negedge clk);
  endtask

  // Monitor: every Ack pops the next expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack != '0) begin
        check("ack_onehot", 32'($onehot(ack)), 1);
        check("busy_in_resp", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_idx", 32'(ack), 32'(1) << e.idx);
          check("result", 32'(result), 32'(e.res));
          check("flags", 32'(flags), 32'(e.flags));
          check("cond", 32'(cond), 32'(e.cond));
        end
      end
    end
  end

  initial begin
    int cyc, j;
    rst_n = 1'b0;
    req   = '1;
    op_in = '0;
    a_in  = '0;
    b_in  = '0;
    set_req(0, 2'd0, 16'h0011, 16'h0022);
    set_req(1, 2'd1, 16'h0100, 16'h0200);
    set_req(2, 2'd2, 16'h0003, 16'h0009);
    set_req(3, 2'd3, 16'hABCD, 16'hABCD);
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_cond", 32'(cond), 0);
    check("rst_busy", 32'(busy), 0);

    // Fairness: all requesters held continuously, served 0,1,2,3,0,.. every 3 cycles.
    for (int i = 0; i < 8; i++)
      exp_q.push_back(model(i % N, op_in[2*(i%N) +: 2], a_in[16*(i%N) +: 16], b_in[16*(i%N) +: 16]));
    rst_n = 1'b1;
    cyc = 0;
    j = 0;
    while (j < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        check("fair_cycle", cyc, 2 + 3*j);
        j++;
        if (j == 8) req = '0;
      end
    end
    check("fair_count", j, 8);
    req = '0;
    mptr = 0;
    @(negedge clk);

    // Directed single operations on requester 1.
    set_req(1, 2'd0, 16'hFFFF, 16'h0001);
    run_round(4'b0010, 0);
    check("add_wrap_res", 32'(result), 32'h0000);
    check("add_wrap_zc", 32'(flags[1:0]), 32'h3);
    set_req(1, 2'd1, 16'h0005, 16'h0007);
    run_round(4'b0010, 0);
    check("sub_res", 32'(result), 32'hFFFE);
    check("sub_cond", 32'(cond), 0);
    check("sub_sign", 32'(flags[2]), 1);
    set_req(1, 2'd2, 16'h0003, 16'h0005);
    run_round(4'b0010, 0);
    check("less_3_5_cond", 32'(cond), 1);
    check("less_3_5_res", 32'(result), 32'h0002);
    set_req(1, 2'd2, 16'h0005, 16'h0005);
    run_round(4'b0010, 0);
    check("less_eq_cond", 32'(cond), 0);
    set_req(1, 2'd2, 16'h8000, 16'h7FFF);
    run_round(4'b0010, 0);
    check("less_unsigned_cond", 32'(cond), 0);
    set_req(1, 2'd3, 16'h1234, 16'h1234);
    run_round(4'b0010, 0);
    check("eq_cond", 32'(cond), 1);

    // Operands flipped during EXEC must not affect the result.
    set_req(1, 2'd0, 16'h1000, 16'h0234);
    run_round(4'b0010, 1);
    check("stable_res", 32'(result), 32'h1234);

    // Randomized rounds with arbitrary requester subsets.
    for (int r = 0; r < 60; r++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        logic [15:0] x, y;
        x = pick();
        y = ($urandom_range(0, 3) == 0) ? x : pick();
        set_req(k, 2'($urandom_range(0, 3)), x, y);
      end
      run_round(mask, 0);
    end

    // Reset in EXEC of a requester-2 op: no Ack, then re-served from ptr 0.
    set_req(2, 2'd0, 16'h4321, 16'h1111);
    req = 4'b0100;
    @(negedge clk);
    check("midrst_busy_exec", 32'(busy), 1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ack", 32'(ack), 0);
    end
    check("midrst_result", 32'(result), 0);
    check("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    mptr = 0;
    run_round(4'b0100, 0);
    check("midrst_after_res", 32'(result), 32'h5432);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
